// File: rtl/vpu_seq_ctrl.sv
// Phase sequencer for an LDPC decoder VPU: channel load (INIT), then alternating
// check-node (CPU) and variable-node (VPU) passes until syndrome OK or iteration limit.
module vpu_seq_ctrl #(
  parameter int BLK_LEN = 256,
  parameter int ITER_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              cpu_done,
  input  logic              syn_ok,
  output logic              initial_on,
  output logic              vpu_on,
  output logic              cpu_on,
  output logic              busy,
  output logic              done,
  output logic              dec_success,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int BEAT_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CPU,
    S_VPU,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   max_q, max_d;
  logic                succ_q, succ_d;
  logic                initial_on_q, vpu_on_q, cpu_on_q, busy_q, done_q;

  logic last_beat;
  assign last_beat = (beat_q == LAST_BEAT);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    iter_d  = iter_q;
    max_d   = max_q;
    succ_d  = succ_q;

    // Abort bypasses the enable so a frozen pipeline can still be torn down.
    if (abort) begin
      state_d = S_IDLE;
      beat_d  = '0;
    end else if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_INIT;
            beat_d  = '0;
            iter_d  = '0;
            succ_d  = 1'b0;
            max_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
          end
        end
        S_INIT: begin
          if (last_beat) begin
            state_d = S_CPU;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        S_CPU: begin
          // Spending at least one cycle here drops the address-generator
          // enables so it reloads its row start addresses.
          if (cpu_done) begin
            beat_d = '0;
            if (syn_ok || (iter_q == max_q)) begin
              state_d = S_FINISH;
              succ_d  = syn_ok;
            end else begin
              state_d = S_VPU;
            end
          end
        end
        S_VPU: begin
          if (last_beat) begin
            state_d = S_CPU;
            beat_d  = '0;
            iter_d  = iter_q + ITER_W'(1);
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      iter_q       <= '0;
      max_q        <= '0;
      succ_q       <= 1'b0;
      initial_on_q <= 1'b0;
      vpu_on_q     <= 1'b0;
      cpu_on_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      iter_q       <= iter_d;
      max_q        <= max_d;
      succ_q       <= succ_d;
      // Outputs are decoded from the next state so they line up with state_q.
      initial_on_q <= (state_d == S_INIT);
      vpu_on_q     <= (state_d == S_VPU);
      cpu_on_q     <= (state_d == S_CPU);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_FINISH);
    end
  end

  assign initial_on  = initial_on_q;
  assign vpu_on      = vpu_on_q;
  assign cpu_on      = cpu_on_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dec_success = succ_q;
  assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Scoreboard bench for vpu_seq_ctrl: stimulus queues the expected output-change
// events (outputs, iter_cnt, dec_success, cycles since previous change); a monitor pops them.
module tb_vpu_seq_ctrl;

  localparam int ITER_W = 5;

  logic              clk = 1'b0;
  logic              rst, en, start, abort, cpu_done, syn_ok;
  logic [ITER_W-1:0] max_iter;
  logic              initial_on, vpu_on, cpu_on, busy, done, dec_success;
  logic [ITER_W-1:0] iter_cnt;

  vpu_seq_ctrl #(.BLK_LEN(256), .ITER_W(ITER_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .abort       (abort),
    .max_iter    (max_iter),
    .cpu_done    (cpu_done),
    .syn_ok      (syn_ok),
    .initial_on  (initial_on),
    .vpu_on      (vpu_on),
    .cpu_on      (cpu_on),
    .busy        (busy),
    .done        (done),
    .dec_success (dec_success),
    .iter_cnt    (iter_cnt)
  );

  always #5 clk = ~clk;

  // Output vector order: {initial_on, vpu_on, cpu_on, busy, done}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_INIT = 5'b10010;
  localparam logic [4:0] O_CPU  = 5'b00110;
  localparam logic [4:0] O_VPU  = 5'b01010;
  localparam logic [4:0] O_FIN  = 5'b00011;

  typedef struct {
    logic [4:0] outs;
    int         iter;
    logic       succ;
    int         gap;   // 0 = gap not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   mon_en = 1'b0;
  logic [10:0] prev_vec;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [4:0] o, input int it, input logic s, input int g);
    exp_t e;
    e.outs = o;
    e.iter = it;
    e.succ = s;
    e.gap  = g;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the observable outputs must match the next queued event.
  exp_t        mon_e;
  logic [10:0] cur_vec;
  always @(negedge clk) begin
    cur_vec = {initial_on, vpu_on, cpu_on, busy, done, iter_cnt, dec_success};
    if (mon_en && (cur_vec != prev_vec)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'(cur_vec), int'(prev_vec));
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_outs", int'(cur_vec[10:6]), int'(mon_e.outs));
        check("ev_iter", int'(iter_cnt), mon_e.iter);
        check("ev_succ", int'(dec_success), int'(mon_e.succ));
        if (mon_e.gap != 0) check("ev_gap", cyc - last_cyc, mon_e.gap);
      end
      last_cyc = cyc;
    end
    prev_vec = cur_vec;
  end

  task automatic start_dec(input logic [ITER_W-1:0] m);
    max_iter = m;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_cpu();
    int t = 0;
    while (!cpu_on && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("wait_cpu_on", int'(cpu_on), 1);
  endtask

  // Check-node responder: answer 4 cycles after CPU entry.
  task automatic cpu_respond(input logic syn);
    wait_cpu();
    repeat (3) @(negedge clk);
    cpu_done = 1'b1;
    syn_ok   = syn;
    @(negedge clk);
    cpu_done = 1'b0;
    syn_ok   = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle_busy", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0;
    max_iter = '0; cpu_done = 1'b0; syn_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", int'({initial_on, vpu_on, cpu_on, busy, done}), 0);
    check("rst_iter", int'(iter_cnt), 0);
    check("rst_succ", int'(dec_success), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Full run to the iteration limit: 3 VPU passes, then FINISH/done.
    push(O_INIT, 0, 1'b0, 0);
    push(O_CPU,  0, 1'b0, 256);
    push(O_VPU,  0, 1'b0, 4);
    push(O_CPU,  1, 1'b0, 256);
    push(O_VPU,  1, 1'b0, 4);
    push(O_CPU,  2, 1'b0, 256);
    push(O_VPU,  2, 1'b0, 4);
    push(O_CPU,  3, 1'b0, 256);
    push(O_FIN,  3, 1'b0, 4);
    push(O_IDLE, 3, 1'b0, 1);
    start_dec(5'd3);
    repeat (4) cpu_respond(1'b0);
    wait_idle();
    check("a_hold_iter", int'(iter_cnt), 3);

    // Syndrome clean on first check: no VPU pass, iter_cnt cleared to 0.
    push(O_INIT, 0, 1'b0, 0);
    push(O_CPU,  0, 1'b0, 256);
    push(O_FIN,  0, 1'b1, 4);
    push(O_IDLE, 0, 1'b1, 1);
    start_dec(5'd3);
    cpu_respond(1'b1);
    wait_idle();

    // max_iter=0 acts as 1; en low 10 cycles mid-VPU stretches the pass to 266.
    push(O_INIT, 0, 1'b0, 0);
    push(O_CPU,  0, 1'b0, 256);
    push(O_VPU,  0, 1'b0, 4);
    push(O_CPU,  1, 1'b0, 266);
    push(O_FIN,  1, 1'b0, 4);
    push(O_IDLE, 1, 1'b0, 1);
    start_dec(5'd0);
    cpu_respond(1'b0);
    repeat (50) @(negedge clk);
    en = 1'b0; start = 1'b1; cpu_done = 1'b1; syn_ok = 1'b1;
    repeat (10) @(negedge clk);
    check("frz_vpu_on", int'(vpu_on), 1);
    en = 1'b1; start = 1'b0; cpu_done = 1'b0; syn_ok = 1'b0;
    cpu_respond(1'b0);
    wait_idle();

    // Abort at INIT beat 100 together with start (and en low): straight to IDLE.
    push(O_INIT, 0, 1'b0, 0);
    push(O_IDLE, 0, 1'b0, 101);
    start_dec(5'd5);
    repeat (100) @(negedge clk);
    abort = 1'b1; start = 1'b1; en = 1'b0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; en = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_init_on", int'(initial_on), 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", int'(done), 0);

    // start with en low in IDLE is ignored.
    en = 1'b0; start = 1'b1; max_iter = 5'd2;
    repeat (3) @(negedge clk);
    en = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("en0_start_busy", int'(busy), 0);

    // Reset in CPU with cpu_done/syn_ok: IDLE with everything cleared, no FINISH.
    push(O_INIT, 0, 1'b0, 0);
    push(O_CPU,  0, 1'b0, 256);
    push(O_VPU,  0, 1'b0, 4);
    push(O_CPU,  1, 1'b0, 256);
    push(O_IDLE, 0, 1'b0, 1);
    start_dec(5'd2);
    cpu_respond(1'b0);
    wait_cpu();
    rst = 1'b1; cpu_done = 1'b1; syn_ok = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_done = 1'b0; syn_ok = 1'b0;
    check("rst_mid_outs", int'({initial_on, vpu_on, cpu_on, busy, done}), 0);
    repeat (10) @(negedge clk);
    check("rst_mid_done", int'(done), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
